// File: rtl/xuy_g_pkg.sv
// Shared constants and types for the xuy_g Boolean-function block.
// TRUTH_MASK bit i is the value of F for input index {A,B,C,D} = i.
package xuy_g_pkg;

  typedef logic [3:0]  idx_t;
  typedef logic [15:0] mask_t;

  localparam mask_t TRUTH_MASK = 16'hF830;
  localparam mask_t ALL_SEEN   = 16'hFFFF;

  function automatic mask_t idx_onehot(input idx_t idx);
    return mask_t'(1) << idx;
  endfunction

endpackage

// File: rtl/xuy_g_if.sv
// Bundle of the operand inputs and observed outputs of xuy_g.
// The master side drives the operands; the slave side is the block itself.
interface xuy_g_if #(
  parameter int CNT_W = 16
) ();
  import xuy_g_pkg::*;

  logic             A;
  logic             B;
  logic             C;
  logic             D;
  logic             F;
  logic             F_q;
  logic [CNT_W-1:0] ones_cnt;
  mask_t            seen;
  logic             all_seen;

  modport master (
    output A, B, C, D,
    input  F, F_q, ones_cnt, seen, all_seen
  );

  modport slave (
    input  A, B, C, D,
    output F, F_q, ones_cnt, seen, all_seen
  );
endinterface

// File: rtl/xuy_g_core.sv
// Gate-level combinational core: F = A(CD + B) + BC'.
// Kept as explicit primitives so the netlist mirrors the algebraic form.
module xuy_g_core (
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic F
);
  logic cd;
  logic cd_or_b;
  logic a_term;
  logic c_n;
  logic bc_term;

  and g_cd      (cd,      C,  D);
  or  g_cd_or_b (cd_or_b, cd, B);
  and g_a_term  (a_term,  A,  cd_or_b);
  not g_c_n     (c_n,     C);
  and g_bc_term (bc_term, B,  c_n);
  or  g_f       (F,       a_term, bc_term);

endmodule

// File: rtl/xuy_g.sv
// Top level: combinational F plus its registered copy, a saturating count
// of F-high cycles and a sticky coverage mask of sampled input indices.
module xuy_g
  import xuy_g_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             F,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  output logic             F_q,
  output logic [CNT_W-1:0] ones_cnt,
  output mask_t            seen,
  output logic             all_seen
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  idx_t             idx;
  logic             f_dly_d, f_dly_q;
  logic [CNT_W-1:0] ones_cnt_d, ones_cnt_q;
  mask_t            seen_d, seen_q;

  xuy_g_core u_core (
    .A (A),
    .B (B),
    .C (C),
    .D (D),
    .F (F)
  );

  assign idx = {A, B, C, D};

  always_comb begin
    f_dly_d    = F;
    ones_cnt_d = ones_cnt_q;
    seen_d     = seen_q | idx_onehot(idx);
    // Saturate rather than wrap so a long run of F=1 stays at full scale.
    if (F && (ones_cnt_q != CNT_MAX)) begin
      ones_cnt_d = ones_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_dly_q    <= 1'b0;
      ones_cnt_q <= '0;
      seen_q     <= '0;
    end else begin
      f_dly_q    <= f_dly_d;
      ones_cnt_q <= ones_cnt_d;
      seen_q     <= seen_d;
    end
  end

  assign F_q      = f_dly_q;
  assign ones_cnt = ones_cnt_q;
  assign seen     = seen_q;
  assign all_seen = (seen_q == ALL_SEEN);

endmodule

// File: tb/tb_xuy_g.sv
// Directed bench for xuy_g: truth-table sweep, F_q latency, counting,
// coverage, saturation (second instance with a 4-bit counter) and reset.
module tb_xuy_g;

  typedef struct {
    logic [3:0] idx;
    logic       exp_f;
  } vec_t;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  vec_t vecs [16];

  xuy_g_if #(.CNT_W(16)) bus  ();
  xuy_g_if #(.CNT_W(4))  bus4 ();

  assign bus4.A = bus.A;
  assign bus4.B = bus.B;
  assign bus4.C = bus.C;
  assign bus4.D = bus.D;

  xuy_g #(.CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .F        (bus.F),
    .A        (bus.A),
    .B        (bus.B),
    .C        (bus.C),
    .D        (bus.D),
    .F_q      (bus.F_q),
    .ones_cnt (bus.ones_cnt),
    .seen     (bus.seen),
    .all_seen (bus.all_seen)
  );

  xuy_g #(.CNT_W(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .F        (bus4.F),
    .A        (bus4.A),
    .B        (bus4.B),
    .C        (bus4.C),
    .D        (bus4.D),
    .F_q      (bus4.F_q),
    .ones_cnt (bus4.ones_cnt),
    .seen     (bus4.seen),
    .all_seen (bus4.all_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("check %-14s got %0h expected %0h ok", name, act, exp);
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_idx(input logic [3:0] v);
    {bus.A, bus.B, bus.C, bus.D} = v;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    // Hand-derived truth table of F = A(CD+B) + BC'.
    vecs[0]  = '{4'd0,  1'b0};  vecs[1]  = '{4'd1,  1'b0};
    vecs[2]  = '{4'd2,  1'b0};  vecs[3]  = '{4'd3,  1'b0};
    vecs[4]  = '{4'd4,  1'b1};  vecs[5]  = '{4'd5,  1'b1};
    vecs[6]  = '{4'd6,  1'b0};  vecs[7]  = '{4'd7,  1'b0};
    vecs[8]  = '{4'd8,  1'b0};  vecs[9]  = '{4'd9,  1'b0};
    vecs[10] = '{4'd10, 1'b0};  vecs[11] = '{4'd11, 1'b1};
    vecs[12] = '{4'd12, 1'b1};  vecs[13] = '{4'd13, 1'b1};
    vecs[14] = '{4'd14, 1'b1};  vecs[15] = '{4'd15, 1'b1};

    rst = 1'b1;
    set_idx(4'd0);

    // Combinational sweep, 10 ns per index, while held in reset.
    for (int i = 0; i < 16; i++) begin
      set_idx(vecs[i].idx);
      #1;
      chk($sformatf("F[%0d]", i), 32'(bus.F), 32'(vecs[i].exp_f));
      #9;
    end

    @(negedge clk);
    chk("rst F_q",      32'(bus.F_q),      32'd0);
    chk("rst ones_cnt", 32'(bus.ones_cnt), 32'd0);
    chk("rst seen",     32'(bus.seen),     32'd0);
    chk("rst all_seen", 32'(bus.all_seen), 32'd0);

    // Clocked sweep 0..15 from reset; F_q lags F by one edge.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i > 0) chk($sformatf("F_q sweep%0d", i - 1), 32'(bus.F_q), 32'(vecs[i-1].exp_f));
      rst = 1'b0;
      set_idx(vecs[i].idx);
    end
    @(negedge clk);
    chk("F_q sweep15",    32'(bus.F_q),       32'd1);
    chk("sweep ones",     32'(bus.ones_cnt),  32'd7);
    chk("sweep seen",     32'(bus.seen),      32'hFFFF);
    chk("sweep all_seen", 32'(bus.all_seen),  32'd1);
    chk("sweep ones4",    32'(bus4.ones_cnt), 32'd7);

    // 0100, 1011, 1010 one per cycle.
    set_idx(4'b0100); #1; chk("seq F 0100", 32'(bus.F), 32'd1);
    @(negedge clk);   chk("seq F_q 0100", 32'(bus.F_q), 32'd1);
    set_idx(4'b1011); #1; chk("seq F 1011", 32'(bus.F), 32'd1);
    @(negedge clk);   chk("seq F_q 1011", 32'(bus.F_q), 32'd1);
    set_idx(4'b1010); #1; chk("seq F 1010", 32'(bus.F), 32'd0);
    @(negedge clk);   chk("seq F_q 1010", 32'(bus.F_q), 32'd0);
    chk("seq ones", 32'(bus.ones_cnt), 32'd9);

    // Saturation: 4-bit counter at 9 plus 20 F-high cycles stops at 15.
    set_idx(4'b1111);
    repeat (20) @(negedge clk);
    chk("sat ones4", 32'(bus4.ones_cnt), 32'd15);
    chk("sat ones16", 32'(bus.ones_cnt), 32'd29);

    // Reset mid-sweep at index 8.
    rst = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      rst = 1'b0;
      set_idx(vecs[i].idx);
    end
    chk("mid ones pre", 32'(bus.ones_cnt), 32'd2);
    chk("mid seen pre", 32'(bus.seen),     32'h00FF);
    rst = 1'b1;
    @(negedge clk);
    chk("mid F_q",      32'(bus.F_q),      32'd0);
    chk("mid ones",     32'(bus.ones_cnt), 32'd0);
    chk("mid seen",     32'(bus.seen),     32'd0);
    chk("mid all_seen", 32'(bus.all_seen), 32'd0);
    chk("mid F idx8",   32'(bus.F),        32'd0);
    set_idx(4'd12); #1;
    chk("mid F idx12",  32'(bus.F),        32'd1);

    // Hold 0000 for 10 cycles after reset.
    @(negedge clk);
    rst = 1'b0;
    set_idx(4'd0);
    repeat (10) @(negedge clk);
    chk("zero ones",     32'(bus.ones_cnt), 32'd0);
    chk("zero seen",     32'(bus.seen),     32'h0001);
    chk("zero all_seen", 32'(bus.all_seen), 32'd0);
    chk("zero F_q",      32'(bus.F_q),      32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/xuy_g.md
XUY_G -- requirements
Module: xuy_g

Interface
REQ-001 Parameter CNT_W, default 16, width of the F-high cycle counter (legal range 4..32).
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 F  output  1  combinational Boolean result, F = A(CD+B) + BC'.
REQ-006 A  input  1  operand, MSB of the 4-bit input index {A,B,C,D}.
REQ-007 B  input  1  operand.
REQ-008 C  input  1  operand.
REQ-009 D  input  1  operand, LSB of the input index.
REQ-010 F_q  output  1  F registered on clk.
REQ-011 ones_cnt  output  CNT_W  saturating count of cycles with F=1.
REQ-012 seen  output  16  input-combination coverage mask, bit i set once index {A,B,C,D}=i is sampled.
REQ-013 all_seen  output  1  high when seen equals 16'hFFFF.
REQ-014 Port order: clk, rst, F, A, B, C, D, F_q, ones_cnt, seen, all_seen.

Function
REQ-015 F shall be purely combinational, with zero latency from A..D and no dependence on clk or rst.
REQ-016 F shall be 1 exactly for indices 4, 5, 11, 12, 13, 14, 15 (truth mask 16'hF830) and 0 for all other indices.
REQ-017 F_q shall equal the value F had at the previous rising clk edge (1-cycle latency).
REQ-018 ones_cnt shall increment by 1 on each rising edge where F=1 and rst=0.
REQ-019 ones_cnt shall hold at all-ones (2^CNT_W-1) instead of wrapping.
REQ-020 seen shall OR in the one-hot bit (1 << {A,B,C,D}) on every non-reset rising edge, and bits shall never clear except by rst.
REQ-021 all_seen shall be combinational from seen.
REQ-022 X or Z on any input is out of scope, and no requirement applies.

Reset
REQ-023 On a rising edge with rst=1: F_q=0, ones_cnt=0, seen=16'h0000, all_seen=0.
REQ-024 rst shall take priority over increment and mask update in the same cycle.
REQ-025 F shall remain valid and unaffected during reset.
REQ-026 Asserting rst mid-sequence shall restart counting and coverage from zero on the next non-reset edge.

Structure
REQ-027 A shared package xuy_g_pkg shall hold the constants TRUTH_MASK=16'hF830 and ALL_SEEN=16'hFFFF.
REQ-028 One sub-module, xuy_g_core, shall implement F using gate-level primitives only (and, or, not), structured as AND(C,D), OR with B, AND with A, AND(B, NOT C), final OR.
REQ-029 The top level shall instantiate xuy_g_core and contain all sequential logic.

Verification
REQ-030 Exhaustive sweep of {A,B,C,D} = 0..15, one value per 10 ns -> F matches TRUTH_MASK bit for every index, with no clock required.
REQ-031 Apply 4'b0100, then 4'b1011, then 4'b1010, one per cycle -> F = 1, 1, 0 respectively, with F_q following one cycle later.
REQ-032 After reset, clock the 0..15 sweep once -> ones_cnt=7, seen=16'hFFFF, all_seen=1.
REQ-033 With CNT_W=4, hold 4'b1111 for 20 cycles -> ones_cnt stops at 15.
REQ-034 Assert rst mid-sweep at index 8 -> next cycle F_q=0, ones_cnt=0, seen=0, while F still tracks the inputs.
REQ-035 Hold 4'b0000 for 10 cycles after reset -> ones_cnt=0, seen=16'h0001, all_seen=0.
